alu181_nibble_seq: RTL and testbench
====================================

// Module: alu181_nibble_seq
// PURPOSE
//  Nibble-serial sequencer that drives the 74181 4-bit ALU function over multi-nibble operands.
//  It accepts one command beat, then NIBBLES operand beats, least-significant nibble first.
//  Per operand beat it evaluates one 74181 slice and chains the carry to the next beat in a register.
//  It presents the assembled result with a valid/ready handshake. Sits upstream of the tt_um top-level pin mux.
// PARAMETERS
//  NIBBLES  4  operand width in nibbles (operand/result width W = 4*NIBBLES); legal 1..8
// PORTS
//  clk        in   1    clock, rising edge
//  rst_n      in   1    asynchronous active-low reset
//  in_valid   in   1    input beat valid
//  in_ready   out  1    block accepts beat when in_valid&in_ready
//  in_data    in   8    cmd beat: {2'b0,cnb,m,s[3:0]}; operand beat: {b_nib[3:0],a_nib[3:0]}
//  out_valid  out  1    result available
//  out_ready  in   1    consumer takes result when out_valid&out_ready
//  res_f      out  W    function result F
//  res_coutb  out  1    active-low carry out (Cn+4) of last nibble
//  res_aeqb   out  1    1 when every nibble's F==4'hF
//  res_pb     out  1    active-low group propagate (see CONFIGURATION)
//  res_gb     out  1    active-low group generate (see CONFIGURATION)
// BEHAVIOUR
//  Clock clk, single domain. Reset rst_n is asynchronous, active-low.
//  Reset: state=IDLE; in_ready=1; out_valid=0; res_f=0; res_coutb=1; res_aeqb=0; res_pb=1; res_gb=1.
//  Data are active-high; cnb and coutb are active-low carries, as in the 74181.
//  FSM IDLE: in_ready=1; accepted beat latches s, m, cnb; carry_reg<=cnb; cnt<=0; aeq_acc<=1; go OPER.
//  FSM OPER: in_ready=1. Each accepted beat evaluates the slice with (a_nib, b_nib, s, m, carry_reg).
//  - F nibble is written into res_f[4*cnt+:4]; carry_reg<=Cn+4; aeq_acc<=aeq_acc&(F==4'hF).
//  - On beat cnt==NIBBLES-1: capture res_coutb, res_aeqb and P/G; go DONE. Otherwise cnt<=cnt+1.
//  FSM DONE: in_ready=0; out_valid=1. All result outputs are stable while out_valid=1.
//  - On out_ready, go IDLE next cycle; out_valid drops that same edge.
//  Latency: result is valid the cycle after the last operand beat is accepted. No same-cycle bypass.
//  in_valid low stalls OPER indefinitely with no state change. Gaps between beats are legal.
//  Reserved command bits [7:6] are ignored.
//  In M=1 (logic) mode the carry chain still threads; res_coutb reports the slice output as computed.
//  res_f holds the last result until the next completed operation overwrites it nibble by nibble.
//  Reset mid-OPER or mid-DONE: discard partial operation and return to IDLE with reset values.
//  cnt width = $clog2(NIBBLES)+1; no wrap, since cnt never exceeds NIBBLES-1.
// CONFIGURATION
//  ALU181_GROUP_PG_EN defined: res_pb/res_gb follow 74182 group lookahead across all nibbles.
//  - Group P = AND of per-nibble P; group G = G[n-1] | P[n-1]&G[n-2] | ... (active-low on the ports).
//  - Accumulate serially in OPER, one term per beat.
//  ALU181_GROUP_PG_EN undefined: no P/G logic; res_pb=1, res_gb=1 constantly.
// STRUCTURE
//  Package alu181_pkg: FSM state enum {IDLE,OPER,DONE}; cmd field offsets; localparams S_ADD=4'b1001, S_SUB=4'b0110.
//  Sub-module alu181_slice: combinational 74181 truth table, all 32 functions.
//  - Inputs: a, b, s, m, cnb. Outputs: f, cn4b, pb, gb, aeqb.
//  - Instantiated once and time-multiplexed across beats.
// TESTING
//  add: cmd {s=1001,m=0,cnb=1}, A=0x1234, B=0x0FFF -> res_f=0x2233, res_coutb=1, res_aeqb=0.
//  add overflow: A=0xFFFF, B=0x0001, s=1001, m=0, cnb=1 -> res_f=0x0000, res_coutb=0.
//  sub: s=0110, m=0, cnb=0, A=0x0005, B=0x0003 -> res_f=0x0002, res_coutb=0.
//  equality: s=0110, m=0, cnb=1, A=B=0xABCD -> res_f=0xFFFF, res_aeqb=1.
//  logic xor: s=0110, m=1, A=0xF0F0, B=0xFF00 -> res_f=0x0FF0.
//  - Hold out_ready=0 for 5 cycles: in_ready=0, out_valid and outputs stable.
//  - Insert in_valid gaps between beats: same result as with no gaps.
//  reset: assert rst_n=0 after 2 operand beats -> IDLE, in_ready=1, out_valid=0.
//  - A new full operation after reset completes correctly.

Source files
------------

// File: rtl/alu181_pkg.sv
// alu181_pkg: FSM states, command field offsets and common 74181 select codes.
package alu181_pkg;
    typedef enum logic [1:0] {IDLE, OPER, DONE} state_t;
    localparam int CMD_S_LSB = 0;
    localparam int CMD_M     = 4;
    localparam int CMD_CNB   = 5;
    localparam logic [3:0] S_ADD = 4'b1001;
    localparam logic [3:0] S_SUB = 4'b0110;
endpackage

// File: rtl/alu181_slice.sv
// alu181_slice: combinational 74181 4-bit ALU slice, all 32 functions, active-high data.
module alu181_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] s,
    input  logic       m,
    input  logic       cnb,
    output logic [3:0] f,
    output logic       cn4b,
    output logic       pb,
    output logic       gb,
    output logic       aeqb
);
    logic [3:0] p, g;
    logic c0, c1, c2, c3, c4;
    assign p  = a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
    assign g  = a & ((b & {4{s[3]}}) | (~b & {4{s[2]}}));
    assign c0 = ~cnb;
    assign c1 = g[0] | (p[0] & c0);
    assign c2 = g[1] | (p[1] & c1);
    assign c3 = g[2] | (p[2] & c2);
    assign c4 = g[3] | (p[3] & c3);
    // logic mode forces every internal carry high, which turns the half-sum into its complement
    assign f    = (p & ~g) ^ ({c3, c2, c1, c0} | {4{m}});
    assign cn4b = ~c4;
    assign pb   = ~&p;
    assign gb   = ~(g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]));
    assign aeqb = &f;
endmodule

// File: rtl/alu181_nibble_seq.sv
// alu181_nibble_seq: nibble-serial 74181 sequencer with valid/ready result handshake.
// Define ALU181_GROUP_PG_EN to build 74182-style group propagate/generate outputs.
module alu181_nibble_seq
    import alu181_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [7:0]             in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   res_f,
    output logic                   res_coutb,
    output logic                   res_aeqb,
    output logic                   res_pb,
    output logic                   res_gb
);
    localparam int CW = $clog2(NIBBLES) + 1;

    state_t state, state_nx;
    logic [3:0] s_reg, f;
    logic m_reg, carry_reg, aeq_acc, acc, last, cn4b, pb, gb, aeqb;
    logic [CW-1:0] cnt;

    assign in_ready  = state != DONE;
    assign out_valid = state == DONE;
    assign acc       = in_valid & in_ready;
    assign last      = cnt == CW'(NIBBLES - 1);

    alu181_slice u_slice (
        .a    (in_data[3:0]),
        .b    (in_data[7:4]),
        .s    (s_reg),
        .m    (m_reg),
        .cnb  (carry_reg),
        .f    (f),
        .cn4b (cn4b),
        .pb   (pb),
        .gb   (gb),
        .aeqb (aeqb)
    );

    always_comb begin
        state_nx = (state == IDLE && acc)         ? OPER :
                   (state == OPER && acc && last) ? DONE :
                   (state == DONE && out_ready)   ? IDLE : state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            s_reg     <= '0;
            m_reg     <= 1'b0;
            carry_reg <= 1'b1;
            cnt       <= '0;
            aeq_acc   <= 1'b1;
            res_f     <= '0;
            res_coutb <= 1'b1;
            res_aeqb  <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && acc) begin
                s_reg     <= in_data[CMD_S_LSB +: 4];
                m_reg     <= in_data[CMD_M];
                carry_reg <= in_data[CMD_CNB];
                cnt       <= '0;
                aeq_acc   <= 1'b1;
            end else if (state == OPER && acc) begin
                res_f[4*cnt +: 4] <= f;
                carry_reg         <= cn4b;
                aeq_acc           <= aeq_acc & aeqb;
                if (last) begin
                    res_coutb <= cn4b;
                    res_aeqb  <= aeq_acc & aeqb;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

`ifdef ALU181_GROUP_PG_EN
    logic p_acc, g_acc, p_nx, g_nx;
    assign p_nx = p_acc & ~pb;
    assign g_nx = ~gb | (~pb & g_acc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_acc  <= 1'b1;
            g_acc  <= 1'b0;
            res_pb <= 1'b1;
            res_gb <= 1'b1;
        end else if (state == IDLE && acc) begin
            p_acc <= 1'b1;
            g_acc <= 1'b0;
        end else if (state == OPER && acc) begin
            p_acc <= p_nx;
            g_acc <= g_nx;
            if (last) begin
                res_pb <= ~p_nx;
                res_gb <= ~g_nx;
            end
        end
    end
`else
    logic unused_pg;
    assign unused_pg = pb ^ gb;
    assign res_pb    = 1'b1;
    assign res_gb    = 1'b1;
`endif
endmodule

// File: tb/tb_alu181_nibble_seq.sv
// tb_alu181_nibble_seq: scoreboard bench with a word-level 74181 reference model.
module tb_alu181_nibble_seq;
    import alu181_pkg::*;

    typedef struct packed {
        logic [15:0] f;
        logic        coutb;
        logic        aeqb;
        logic        pb;
        logic        gb;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n, in_valid, in_ready, out_valid, out_ready;
    logic [7:0] in_data;
    logic [15:0] res_f;
    logic res_coutb, res_aeqb, res_pb, res_gb;
    logic hold;
    int total = 0, bad = 0;
    exp_t q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    alu181_nibble_seq #(.NIBBLES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res_f     (res_f),
        .res_coutb (res_coutb),
        .res_aeqb  (res_aeqb),
        .res_pb    (res_pb),
        .res_gb    (res_gb)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, act, exp);
        end
    endtask

    // Arithmetic mode is the word sum P + G + carry-in; logic mode is ~P | G.
    function automatic exp_t model(input logic [3:0] s, input logic m, input logic cnb,
                                   input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        logic [15:0] p, g;
        logic [16:0] sum, gs;
        p = a | (b & {16{s[0]}}) | (~b & {16{s[1]}});
        g = a & ((b & {16{s[3]}}) | (~b & {16{s[2]}}));
        sum = {1'b0, p} + {1'b0, g} + {16'd0, ~cnb};
        gs  = {1'b0, p} + {1'b0, g};
        e.f     = m ? (~p | g) : sum[15:0];
        e.coutb = ~sum[16];
        e.aeqb  = &e.f;
`ifdef ALU181_GROUP_PG_EN
        e.pb = ~&p;
        e.gb = ~gs[16];
`else
        e.pb = 1'b1;
        e.gb = 1'b1;
`endif
        return e;
    endfunction

    always @(posedge clk) begin
        #2;
        out_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result got=%h exp=none", res_f);
            end else begin
                mon_e = q.pop_front();
                chk("res_f", {16'd0, res_f}, {16'd0, mon_e.f});
                chk("res_coutb", {31'd0, res_coutb}, {31'd0, mon_e.coutb});
                chk("res_aeqb", {31'd0, res_aeqb}, {31'd0, mon_e.aeqb});
                chk("res_pb", {31'd0, res_pb}, {31'd0, mon_e.pb});
                chk("res_gb", {31'd0, res_gb}, {31'd0, mon_e.gb});
                chk("in_ready_done", {31'd0, in_ready}, 32'd0);
            end
        end
    end

    task automatic send(input logic [7:0] d, input int gap);
        int n = 0;
        in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic op(input logic [3:0] s, input logic m, input logic cnb,
                      input logic [15:0] a, input logic [15:0] b, input exp_t e, input int gapmax);
        q.push_back(e);
        send({2'($urandom), cnb, m, s}, $urandom_range(0, gapmax));
        for (int i = 0; i < 4; i++)
            send({b[4*i +: 4], a[4*i +: 4]}, $urandom_range(0, gapmax));
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_queue", q.size(), 32'd0);
        q.delete();
    endtask

    task automatic chk_reset_vals();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_res_f", {16'd0, res_f}, 32'd0);
        chk("rst_coutb", {31'd0, res_coutb}, 32'd1);
        chk("rst_aeqb", {31'd0, res_aeqb}, 32'd0);
        chk("rst_pb", {31'd0, res_pb}, 32'd1);
        chk("rst_gb", {31'd0, res_gb}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        logic [15:0] snap;
        logic [3:0] rs;
        logic rm, rc;
        logic [15:0] ra, rb;
        int n;
        hold = 1'b0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        e = model(S_ADD, 1'b0, 1'b1, 16'h1234, 16'h0FFF);
        e.f = 16'h2233; e.coutb = 1'b1; e.aeqb = 1'b0;
        op(S_ADD, 1'b0, 1'b1, 16'h1234, 16'h0FFF, e, 0);
        op(S_ADD, 1'b0, 1'b1, 16'h1234, 16'h0FFF, e, 3);
        e = model(S_ADD, 1'b0, 1'b1, 16'hFFFF, 16'h0001);
        e.f = 16'h0000; e.coutb = 1'b0;
        op(S_ADD, 1'b0, 1'b1, 16'hFFFF, 16'h0001, e, 0);
        e = model(S_SUB, 1'b0, 1'b0, 16'h0005, 16'h0003);
        e.f = 16'h0002; e.coutb = 1'b0;
        op(S_SUB, 1'b0, 1'b0, 16'h0005, 16'h0003, e, 1);
        e = model(S_SUB, 1'b0, 1'b1, 16'hABCD, 16'hABCD);
        e.f = 16'hFFFF; e.aeqb = 1'b1;
        op(S_SUB, 1'b0, 1'b1, 16'hABCD, 16'hABCD, e, 0);
        e = model(S_SUB, 1'b1, 1'b1, 16'hF0F0, 16'hFF00);
        e.f = 16'h0FF0;
        op(S_SUB, 1'b1, 1'b1, 16'hF0F0, 16'hFF00, e, 2);
        drain();

        // backpressure: result must sit still while the consumer stalls
        hold = 1'b1;
        @(posedge clk);
        #3;
        e = model(S_ADD, 1'b0, 1'b1, 16'h1234, 16'h0FFF);
        e.f = 16'h2233;
        op(S_ADD, 1'b0, 1'b1, 16'h1234, 16'h0FFF, e, 0);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
        snap = res_f;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
            chk("hold_res_f", {16'd0, res_f}, {16'd0, snap});
        end
        hold = 1'b0;
        drain();

        // abort after two operand beats
        send({2'b00, 1'b1, 1'b0, S_ADD}, 0);
        send(8'h34, 0);
        send(8'h12, 0);
        rst_n = 1'b0;
        #1;
        chk_reset_vals();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_q", q.size(), 32'd0);
        e = model(S_SUB, 1'b0, 1'b0, 16'h0005, 16'h0003);
        e.f = 16'h0002; e.coutb = 1'b0;
        op(S_SUB, 1'b0, 1'b0, 16'h0005, 16'h0003, e, 1);
        drain();

        for (int k = 0; k < 40; k++) begin
            rs = 4'($urandom);
            rm = 1'($urandom);
            rc = 1'($urandom);
            ra = 16'($urandom);
            rb = (k % 5 == 0) ? ra : 16'($urandom);
            op(rs, rm, rc, ra, rb, model(rs, rm, rc, ra, rb), 2);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
